serial_add_scheduler: RTL and testbench

Round-robin scheduler that shares one 8-bit bit-serial adder between two requesters. It latches a granted requester's operands into internal LSB-first shift registers and steps a full adder plus carry flop one bit per clock. It then returns the registered sum, carry-out and requester ID with a single-cycle done pulse. It sits between the two operand sources and any downstream consumer of serial-add results, so neither requester drives the serial datapath directly.

---
 rtl/serial_add_scheduler_if.sv | 27 ++
 rtl/serial_add_scheduler.sv | 119 +++++++++++
 tb/tb_serial_add_scheduler.sv | 346 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_add_scheduler_if.sv
// Requester/result bundle for serial_add_scheduler: two operand request ports
// plus the shared result and grant/done handshake.
interface serial_add_scheduler_if #(parameter int W = 8);
  logic         req0;
  logic [W-1:0] a0;
  logic [W-1:0] b0;
  logic         req1;
  logic [W-1:0] a1;
  logic [W-1:0] b1;
  logic         gnt0;
  logic         gnt1;
  logic         busy;
  logic         done;
  logic         done_id;
  logic [W-1:0] sum;
  logic         cout;

  modport master (
    output req0, a0, b0, req1, a1, b1,
    input  gnt0, gnt1, busy, done, done_id, sum, cout
  );

  modport slave (
    input  req0, a0, b0, req1, a1, b1,
    output gnt0, gnt1, busy, done, done_id, sum, cout
  );
endinterface

// File: rtl/serial_add_scheduler.sv
// Round-robin scheduler sharing one bit-serial W-bit adder between two
// requesters; returns sum, carry-out and owner ID with a one-cycle done pulse.
module serial_add_scheduler #(
  parameter int W = 8
) (
  input  logic                  clk,
  input  logic                  clr_n,
  serial_add_scheduler_if.slave bus
);

  localparam int CW = (W > 2) ? $clog2(W) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t        state_q;
  logic [W-1:0]  a_sr_q;
  logic [W-1:0]  b_sr_q;
  logic [CW-1:0] cnt_q;
  logic          carry_q;
  logic          owner_q;
  logic          last_id_q;
  logic [W-1:0]  sum_q;
  logic          cout_q;
  logic          done_q;
  logic          done_id_q;
  logic          gnt0_q;
  logic          gnt1_q;
  logic          busy_q;

  logic          any_req;
  logic          win_id;
  logic          fa_s;
  logic          carry_d;
  logic [W-1:0]  a_sr_d;

  always_comb begin
    any_req = bus.req0 | bus.req1;
    // On a tie the requester that did not win last time is chosen.
    win_id  = bus.req1 & (~bus.req0 | ~last_id_q);
    fa_s    = a_sr_q[0] ^ b_sr_q[0] ^ carry_q;
    carry_d = (a_sr_q[0] & b_sr_q[0]) | (a_sr_q[0] & carry_q) | (b_sr_q[0] & carry_q);
    // Sum bits fill the MSB end of the a register as its LSBs are consumed,
    // so after W steps it holds the complete result.
    a_sr_d  = {fa_s, a_sr_q[W-1:1]};
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state_q   <= S_IDLE;
      a_sr_q    <= '0;
      b_sr_q    <= '0;
      cnt_q     <= '0;
      carry_q   <= 1'b0;
      owner_q   <= 1'b0;
      last_id_q <= 1'b1;
      sum_q     <= '0;
      cout_q    <= 1'b0;
      done_q    <= 1'b0;
      done_id_q <= 1'b0;
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      gnt0_q <= 1'b0;
      gnt1_q <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (any_req) begin
            a_sr_q    <= win_id ? bus.a1 : bus.a0;
            b_sr_q    <= win_id ? bus.b1 : bus.b0;
            carry_q   <= 1'b0;
            cnt_q     <= '0;
            owner_q   <= win_id;
            last_id_q <= win_id;
            gnt0_q    <= ~win_id;
            gnt1_q    <= win_id;
            busy_q    <= 1'b1;
            state_q   <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          a_sr_q  <= a_sr_d;
          b_sr_q  <= {1'b0, b_sr_q[W-1:1]};
          carry_q <= carry_d;
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == CW'(W - 1)) begin
            sum_q     <= a_sr_d;
            cout_q    <= carry_d;
            done_id_q <= owner_q;
            done_q    <= 1'b1;
            state_q   <= S_DONE;
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.gnt0    = gnt0_q;
  assign bus.gnt1    = gnt1_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.done_id = done_id_q;
  assign bus.sum     = sum_q;
  assign bus.cout    = cout_q;

endmodule

// File: tb/tb_serial_add_scheduler.sv
// Self-checking bench for serial_add_scheduler: grant-time scoreboard plus
// per-scenario timing and value checks.
module tb_serial_add_scheduler;

  localparam int W = 8;

  logic clk = 1'b0;
  logic clr_n;
  always #5 clk = ~clk;

  serial_add_scheduler_if #(.W(W)) bus ();

  serial_add_scheduler #(.W(W)) dut (
    .clk   (clk),
    .clr_n (clr_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  logic mon_en = 1'b0;

  logic [W-1:0] snap_a0, snap_b0, snap_a1, snap_b1;
  logic [W+1:0] sb[$];
  logic [W+1:0] sb_exp;

  // Operands as seen by the DUT at each edge; inputs only change on negedges.
  always @(posedge clk) begin
    cyc     = cyc + 1;
    snap_a0 = bus.a0;
    snap_b0 = bus.b0;
    snap_a1 = bus.a1;
    snap_b1 = bus.b1;
  end

  always @(negedge clk) begin
    if (mon_en) begin
      if (!clr_n) begin
        sb.delete();
      end else begin
        checks = checks + 1;
        if ((bus.gnt0 & bus.gnt1) !== 1'b0) begin
          errors = errors + 1;
          $display("FAIL gnt_exclusive: gnt0=%b gnt1=%b, required not both", bus.gnt0, bus.gnt1);
        end
        checks = checks + 1;
        if (((bus.gnt0 | bus.gnt1) & bus.done) !== 1'b0) begin
          errors = errors + 1;
          $display("FAIL gnt_done_overlap: gnt0=%b gnt1=%b done=%b", bus.gnt0, bus.gnt1, bus.done);
        end
        if (bus.gnt0 === 1'b1) sb.push_back({1'b0, {1'b0, snap_a0} + {1'b0, snap_b0}});
        if (bus.gnt1 === 1'b1) sb.push_back({1'b1, {1'b0, snap_a1} + {1'b0, snap_b1}});
        if (bus.done === 1'b1) begin
          checks = checks + 1;
          if (sb.size() == 0) begin
            errors = errors + 1;
            $display("FAIL sb_unexpected_done: id=%b cout=%b sum=%h with nothing outstanding",
                     bus.done_id, bus.cout, bus.sum);
          end else begin
            sb_exp = sb.pop_front();
            if ({bus.done_id, bus.cout, bus.sum} !== sb_exp) begin
              errors = errors + 1;
              $display("FAIL sb_result: got id/cout/sum %h, expected %h",
                       {bus.done_id, bus.cout, bus.sum}, sb_exp);
            end
          end
        end
      end
    end
  end

  task automatic wait_done(input int budget, output int k);
    k = -1;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        k = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int k;
    clr_n = 1'b0;
    bus.req0 = 1'b1; bus.a0 = 8'h10; bus.b0 = 8'h20;
    bus.req1 = 1'b1; bus.a1 = 8'h80; bus.b1 = 8'h80;
    repeat (3) @(negedge clk);
    checks = checks + 1;
    if ({bus.gnt0, bus.gnt1, bus.busy, bus.done, bus.done_id, bus.cout} !== 6'b0) begin
      errors = errors + 1;
      $display("FAIL reset_ctrl: gnt0/gnt1/busy/done/id/cout=%b, required 000000",
               {bus.gnt0, bus.gnt1, bus.busy, bus.done, bus.done_id, bus.cout});
    end
    checks = checks + 1;
    if (bus.sum !== 8'h00) begin
      errors = errors + 1;
      $display("FAIL reset_sum: got %h, required 00", bus.sum);
    end
    mon_en = 1'b1;
    clr_n  = 1'b1;
    @(negedge clk);
    checks = checks + 1;
    if ({bus.gnt0, bus.gnt1} !== 2'b10) begin
      errors = errors + 1;
      $display("FAIL reset_first_tie: gnt0/gnt1=%b, required 10", {bus.gnt0, bus.gnt1});
    end
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    wait_done(20, k);
    checks = checks + 1;
    if (k !== W) begin
      errors = errors + 1;
      $display("FAIL reset_first_latency: done after %0d cycles, required %0d", k, W);
    end
  endtask

  task automatic test_single();
    int k;
    @(negedge clk);
    bus.a0 = 8'h5A; bus.b0 = 8'h3C; bus.req0 = 1'b1;
    @(negedge clk);
    checks = checks + 1;
    if ({bus.gnt0, bus.gnt1, bus.busy} !== 3'b101) begin
      errors = errors + 1;
      $display("FAIL single_grant: gnt0/gnt1/busy=%b, required 101", {bus.gnt0, bus.gnt1, bus.busy});
    end
    bus.req0 = 1'b0;
    wait_done(20, k);
    checks = checks + 1;
    if (k !== W) begin
      errors = errors + 1;
      $display("FAIL single_latency: gnt-to-done %0d cycles, required %0d", k, W);
    end
    checks = checks + 1;
    if ({bus.done_id, bus.cout, bus.sum} !== {1'b0, 1'b0, 8'h96}) begin
      errors = errors + 1;
      $display("FAIL single_result: id/cout/sum=%b/%b/%h, required 0/0/96", bus.done_id, bus.cout, bus.sum);
    end
    @(negedge clk);
    checks = checks + 1;
    if ({bus.done, bus.busy, bus.sum} !== {1'b0, 1'b0, 8'h96}) begin
      errors = errors + 1;
      $display("FAIL single_after_done: done/busy/sum=%b/%b/%h, required 0/0/96", bus.done, bus.busy, bus.sum);
    end
  endtask

  task automatic test_overflow();
    int k;
    logic [W-1:0] oa [2];
    logic [W-1:0] ob [2];
    logic [W+1:0] oexp [2];
    oa[0] = 8'hFF; ob[0] = 8'h01; oexp[0] = {1'b1, 1'b1, 8'h00};
    oa[1] = 8'hFF; ob[1] = 8'hFF; oexp[1] = {1'b1, 1'b1, 8'hFE};
    for (int t = 0; t < 2; t++) begin
      @(negedge clk);
      bus.a1 = oa[t]; bus.b1 = ob[t]; bus.req1 = 1'b1;
      @(negedge clk);
      checks = checks + 1;
      if ({bus.gnt0, bus.gnt1} !== 2'b01) begin
        errors = errors + 1;
        $display("FAIL overflow_grant%0d: gnt0/gnt1=%b, required 01", t, {bus.gnt0, bus.gnt1});
      end
      bus.req1 = 1'b0;
      wait_done(20, k);
      checks = checks + 1;
      if (k < 0 || {bus.done_id, bus.cout, bus.sum} !== oexp[t]) begin
        errors = errors + 1;
        $display("FAIL overflow_result%0d: wait=%0d id/cout/sum=%h, required %h",
                 t, k, {bus.done_id, bus.cout, bus.sum}, oexp[t]);
      end
    end
  endtask

  task automatic test_contention();
    int n;
    int ids [4];
    int at  [4];
    logic [W:0] res [4];
    @(negedge clk);
    bus.a0 = 8'h10; bus.b0 = 8'h20;
    bus.a1 = 8'h80; bus.b1 = 8'h80;
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    n = 0;
    for (int i = 0; i < 80 && n < 4; i++) begin
      @(negedge clk);
      bus.req0 = !bus.gnt0;
      bus.req1 = !bus.gnt1;
      if (bus.done === 1'b1) begin
        ids[n] = int'(bus.done_id);
        res[n] = {bus.cout, bus.sum};
        at[n]  = cyc;
        n = n + 1;
      end
    end
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    checks = checks + 1;
    if (n !== 4) begin
      errors = errors + 1;
      $display("FAIL contention_count: %0d completions, required 4", n);
    end
    for (int i = 0; i < n; i++) begin
      checks = checks + 1;
      if (ids[i] !== i % 2) begin
        errors = errors + 1;
        $display("FAIL contention_order%0d: id %0d, required %0d", i, ids[i], i % 2);
      end
      checks = checks + 1;
      if (res[i] !== ((i % 2 == 1) ? 9'h100 : 9'h030)) begin
        errors = errors + 1;
        $display("FAIL contention_result%0d: cout/sum %h, required %h",
                 i, res[i], (i % 2 == 1) ? 9'h100 : 9'h030);
      end
      if (i > 0) begin
        checks = checks + 1;
        if (at[i] - at[i-1] !== W + 2) begin
          errors = errors + 1;
          $display("FAIL contention_spacing%0d: %0d cycles, required %0d", i, at[i] - at[i-1], W + 2);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int k;
    @(negedge clk);
    bus.a0 = 8'hAA; bus.b0 = 8'h55; bus.req0 = 1'b1;
    @(negedge clk);
    checks = checks + 1;
    if (bus.gnt0 !== 1'b1) begin
      errors = errors + 1;
      $display("FAIL midreset_grant: gnt0=%b, required 1", bus.gnt0);
    end
    bus.req0 = 1'b0;
    repeat (3) @(negedge clk);
    clr_n = 1'b0;
    @(negedge clk);
    checks = checks + 1;
    if ({bus.done, bus.busy, bus.gnt0, bus.gnt1, bus.done_id, bus.cout, bus.sum} !== '0) begin
      errors = errors + 1;
      $display("FAIL midreset_clear: done/busy/gnt0/gnt1/id/cout=%b sum=%h, required all 0",
               {bus.done, bus.busy, bus.gnt0, bus.gnt1, bus.done_id, bus.cout}, bus.sum);
    end
    clr_n = 1'b1;
    wait_done(15, k);
    checks = checks + 1;
    if (k !== -1) begin
      errors = errors + 1;
      $display("FAIL midreset_no_done: done seen after %0d cycles, required none", k);
    end
    @(negedge clk);
    bus.a1 = 8'h01; bus.b1 = 8'h02; bus.req1 = 1'b1;
    @(negedge clk);
    checks = checks + 1;
    if ({bus.gnt0, bus.gnt1} !== 2'b01) begin
      errors = errors + 1;
      $display("FAIL midreset_regrant: gnt0/gnt1=%b, required 01", {bus.gnt0, bus.gnt1});
    end
    bus.req1 = 1'b0;
    wait_done(20, k);
    checks = checks + 1;
    if (k !== W || {bus.done_id, bus.cout, bus.sum} !== {1'b1, 1'b0, 8'h03}) begin
      errors = errors + 1;
      $display("FAIL midreset_result: wait=%0d id/cout/sum=%b/%b/%h, required %0d 1/0/03",
               k, bus.done_id, bus.cout, bus.sum, W);
    end
  endtask

  task automatic test_operand_stability();
    int k;
    int k2;
    logic [W-1:0] oa, ob, na, nb;
    logic [W:0]   e1, e2;
    oa = W'($urandom_range(255, 0));
    ob = W'($urandom_range(255, 0));
    na = W'($urandom_range(255, 0));
    nb = W'($urandom_range(255, 0));
    e1 = {1'b0, oa} + {1'b0, ob};
    e2 = {1'b0, na} + {1'b0, nb};
    @(negedge clk);
    bus.a0 = oa; bus.b0 = ob; bus.req0 = 1'b1;
    @(negedge clk);
    checks = checks + 1;
    if (bus.gnt0 !== 1'b1) begin
      errors = errors + 1;
      $display("FAIL stable_grant: gnt0=%b, required 1", bus.gnt0);
    end
    bus.a0 = na; bus.b0 = nb;
    wait_done(20, k);
    checks = checks + 1;
    if (k !== W || {bus.done_id, bus.cout, bus.sum} !== {1'b0, e1}) begin
      errors = errors + 1;
      $display("FAIL stable_first: wait=%0d id/cout/sum=%h, required %0d %h",
               k, {bus.done_id, bus.cout, bus.sum}, W, {1'b0, e1});
    end
    k2 = -1;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (bus.gnt0 === 1'b1) begin
        k2 = i;
        break;
      end
    end
    bus.req0 = 1'b0;
    checks = checks + 1;
    if (k2 !== 2) begin
      errors = errors + 1;
      $display("FAIL stable_regrant: held req0 granted after %0d cycles, required 2", k2);
    end
    wait_done(20, k);
    checks = checks + 1;
    if (k !== W || {bus.done_id, bus.cout, bus.sum} !== {1'b0, e2}) begin
      errors = errors + 1;
      $display("FAIL stable_second: wait=%0d id/cout/sum=%h, required %0d %h",
               k, {bus.done_id, bus.cout, bus.sum}, W, {1'b0, e2});
    end
  endtask

  initial begin
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.a0 = '0; bus.b0 = '0; bus.a1 = '0; bus.b1 = '0;
    test_reset();
    test_single();
    test_overflow();
    test_contention();
    test_reset_mid();
    test_operand_stability();
    repeat (3) @(negedge clk);
    checks = checks + 1;
    if (sb.size() != 0) begin
      errors = errors + 1;
      $display("FAIL sb_drain: %0d results outstanding, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
